operator_sequencer: RTL and testbench
=====================================

Name: operator_sequencer

Overview:
- Per-sample frame controller for the FM operator datapath.
- On each sample tick it walks every voice and, within each voice, operators 0..5. For each step it drives the algorithm ROM address (6-bit algorithm, 3-bit operator) and receives the registered ROM control word one cycle later.
- It holds the per-voice algorithm table, which the host writes.
- It emits a valid-qualified stream of {voice, operator, SEL, MREN, FREN} that steers the modulation/feedback path of the operator pipeline.

Parameters:
- NUM_VOICES, 32, number of voices per frame (≥2).
- VOICE_W, 5, voice index width; equals clog2(NUM_VOICES).
- NUM_OPERATORS, 6, operators per voice (≤8, fits the 3-bit operator field).

Ports:
- i_Clock  in  1  single clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_SampleTick  in  1  start-of-frame pulse.
- i_AlgWriteEnable  in  1  algorithm table write strobe.
- i_AlgWriteVoice  in  VOICE_W  voice to write.
- i_AlgWriteData  in  6  algorithm number.
- i_OverrunClear  in  1  clears o_Overrun.
- o_RomAlgorithm  out  6  algorithm ROM algorithm field.
- o_RomOperator  out  3  algorithm ROM operator field.
- i_SEL  in  3  ROM control word, one cycle after address.
- i_MREN  in  1  ROM control word, one cycle after address.
- i_FREN  in  1  ROM control word, one cycle after address.
- o_Valid  out  1  step output valid.
- o_Voice  out  VOICE_W  voice of current step.
- o_Operator  out  3  operator of current step.
- o_SEL  out  3  control word for current step, gated by o_Valid.
- o_MREN  out  1  control word for current step, gated by o_Valid.
- o_FREN  out  1  control word for current step, gated by o_Valid.
- o_Busy  out  1  frame in progress.
- o_FrameDone  out  1  one-cycle pulse with the last step.
- o_Overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- **Reset values:** all outputs 0; state IDLE; counters 0; algorithm table all 0; o_Overrun 0. Reset mid-frame aborts immediately, with no o_FrameDone.
- **States:**
  - IDLE: address outputs 0. i_SampleTick → ISSUE (voice 0, op 0).
  - ISSUE: presents one address per cycle. Operator increments; at NUM_OPERATORS-1 it wraps to 0 and voice increments. After issuing (NUM_VOICES-1, NUM_OPERATORS-1) → DRAIN.
  - DRAIN: one cycle to present the final ROM result → IDLE.
- **o_Busy:** 1 in ISSUE and DRAIN.
- **Latency:**
  - Tick sampled at edge t → first address driven during cycle t+1.
  - First o_Valid in cycle t+2.
  - Exactly NUM_VOICES×NUM_OPERATORS consecutive valid cycles, no gaps.
  - Tick-to-tick minimum period is NUM_VOICES×NUM_OPERATORS+2 cycles.
- **Alignment:**
  - o_Voice, o_Operator and o_Valid are the address-stage values registered once.
  - o_SEL, o_MREN and o_FREN equal i_SEL, i_MREN and i_FREN while o_Valid=1, else 0.
- **Algorithm latch:**
  - At op 0 of each voice, o_RomAlgorithm is the table entry for that voice, and the value is latched.
  - Ops 1..NUM_OPERATORS-1 use the latched value, so every operator of a voice sees one consistent algorithm.
- **Table writes:**
  - Accepted in any state; the write lands at the clock edge.
  - A write to voice v in the same cycle as v's op-0 read: the old value is used this frame.
  - A write to a voice already latched or already passed takes effect next frame.
  - A write to a voice not yet reached takes effect this frame.
- **Tick while busy:** ignored (the frame continues unchanged) and o_Overrun is set.
- **o_Overrun:** i_OverrunClear clears it the next cycle. If clear and a new overrun occur in the same cycle, set wins.
- **Tick timing:** a tick in the DRAIN cycle counts as busy (overrun). A tick in the cycle after DRAIN starts a new frame.
- **o_FrameDone:** high exactly in the cycle o_Valid shows (NUM_VOICES-1, NUM_OPERATORS-1).
- **Unused ROM entries:** operator codes NUM_OPERATORS..7 are never driven.

Test Plan:
- **Reset:** hold i_Reset 3 cycles → all outputs 0, o_Busy=0. Then tick with the table unwritten → every step has o_RomAlgorithm=0, and exactly 192 valid cycles starting 2 cycles after the tick.
- **Write and sequence:** write voice 3 = 0x2A, then tick → addresses for voice 3 ops 0..5 are 0x2A/0..5. With a ROM model returning word[0x2A*8+k], o_SEL/o_MREN/o_FREN match in the following cycle, with o_Voice=3 and o_Operator=k.
- **Frame end:** o_FrameDone pulses once, coincident with voice 31 op 5. The next cycle has o_Valid=0 and o_Busy=0.
- **Mid-voice write:** write voice 5 = 0x11 in the cycle of voice 5 op 2 → voice 5 still uses the old value for ops 2..5 in this frame. The next frame uses 0x11 for all ops.
- **Overrun:** tick at step 100 → sequence unaffected, o_Overrun=1 and stays set. i_OverrunClear → 0. A tick in the cycle after DRAIN starts a new frame with o_Overrun unchanged.
- **Reset mid-frame:** reset at step 50 → o_Valid=0 and o_Busy=0 next cycle, no o_FrameDone, table cleared. The next tick restarts at voice 0 op 0.

Source files
------------

// File: rtl/operator_sequencer.sv
// Per-sample frame controller: walks every voice/operator pair, drives the algorithm ROM
// address and forwards the registered ROM control word as a valid-qualified step stream.
module operator_sequencer #(
    parameter int unsigned NUM_VOICES    = 32,
    parameter int unsigned VOICE_W       = 5,
    parameter int unsigned NUM_OPERATORS = 6
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               i_SampleTick,
    input  logic               i_AlgWriteEnable,
    input  logic [VOICE_W-1:0] i_AlgWriteVoice,
    input  logic [5:0]         i_AlgWriteData,
    input  logic               i_OverrunClear,
    output logic [5:0]         o_RomAlgorithm,
    output logic [2:0]         o_RomOperator,
    input  logic [2:0]         i_SEL,
    input  logic               i_MREN,
    input  logic               i_FREN,
    output logic               o_Valid,
    output logic [VOICE_W-1:0] o_Voice,
    output logic [2:0]         o_Operator,
    output logic [2:0]         o_SEL,
    output logic               o_MREN,
    output logic               o_FREN,
    output logic               o_Busy,
    output logic               o_FrameDone,
    output logic               o_Overrun
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    localparam logic [VOICE_W-1:0] LastVoice = VOICE_W'(NUM_VOICES - 1);
    localparam logic [2:0]         LastOp    = 3'(NUM_OPERATORS - 1);

    state_e             state_q;
    logic [VOICE_W-1:0] voice_q;
    logic [2:0]         op_q;
    logic [5:0]         alg_latch_q;
    logic [5:0]         alg_tab_q [NUM_VOICES];
    logic               valid_q;
    logic               done_q;
    logic [VOICE_W-1:0] out_voice_q;
    logic [2:0]         out_op_q;
    logic               overrun_q;
    logic               overrun_d;

    logic               issuing;
    logic               busy;
    logic               last_step;
    logic [5:0]         rom_alg;

    always_comb begin
        issuing   = (state_q == StIssue);
        busy      = issuing || (state_q == StDrain);
        last_step = issuing && (voice_q == LastVoice) && (op_q == LastOp);
        rom_alg   = '0;
        // Op 0 reads the table live so a same-cycle write only lands after this read.
        if (issuing) begin
            rom_alg = (op_q == 3'd0) ? alg_tab_q[voice_q] : alg_latch_q;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (i_SampleTick && busy) begin
            overrun_d = 1'b1;
        end else if (i_OverrunClear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                alg_tab_q[i] <= '0;
            end
        end else if (i_AlgWriteEnable) begin
            alg_tab_q[i_AlgWriteVoice] <= i_AlgWriteData;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            voice_q     <= '0;
            op_q        <= '0;
            alg_latch_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            out_voice_q <= '0;
            out_op_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            valid_q     <= issuing;
            done_q      <= last_step;
            out_voice_q <= issuing ? voice_q : '0;
            out_op_q    <= issuing ? op_q : '0;
            unique case (state_q)
                StIdle: begin
                    if (i_SampleTick) begin
                        state_q <= StIssue;
                        voice_q <= '0;
                        op_q    <= '0;
                    end
                end
                StIssue: begin
                    if (op_q == 3'd0) begin
                        alg_latch_q <= alg_tab_q[voice_q];
                    end
                    if (op_q == LastOp) begin
                        op_q <= '0;
                        if (voice_q == LastVoice) begin
                            voice_q <= '0;
                            state_q <= StDrain;
                        end else begin
                            voice_q <= voice_q + 1'b1;
                        end
                    end else begin
                        op_q <= op_q + 1'b1;
                    end
                end
                StDrain: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_RomAlgorithm = rom_alg;
    assign o_RomOperator  = issuing ? op_q : 3'd0;
    assign o_Valid        = valid_q;
    assign o_Voice        = out_voice_q;
    assign o_Operator     = out_op_q;
    assign o_SEL          = valid_q ? i_SEL : 3'd0;
    assign o_MREN         = valid_q & i_MREN;
    assign o_FREN         = valid_q & i_FREN;
    assign o_Busy         = busy;
    assign o_FrameDone    = done_q;
    assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_operator_sequencer.sv
// Scoreboard bench for operator_sequencer: stimulus pushes expected steps, a negedge
// monitor pops and compares them against the DUT stream and a bench-side ROM.
module tb_operator_sequencer;

    localparam int NV      = 32;
    localparam int VW      = 5;
    localparam int NO      = 6;
    localparam int STEPS   = NV * NO;

    logic          clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_SampleTick = 1'b0;
    logic          i_AlgWriteEnable = 1'b0;
    logic [VW-1:0] i_AlgWriteVoice = '0;
    logic [5:0]    i_AlgWriteData = '0;
    logic          i_OverrunClear = 1'b0;
    logic [5:0]    o_RomAlgorithm;
    logic [2:0]    o_RomOperator;
    logic [2:0]    i_SEL;
    logic          i_MREN;
    logic          i_FREN;
    logic          o_Valid;
    logic [VW-1:0] o_Voice;
    logic [2:0]    o_Operator;
    logic [2:0]    o_SEL;
    logic          o_MREN;
    logic          o_FREN;
    logic          o_Busy;
    logic          o_FrameDone;
    logic          o_Overrun;

    always #5 clk = ~clk;

    operator_sequencer #(
        .NUM_VOICES   (NV),
        .VOICE_W      (VW),
        .NUM_OPERATORS(NO)
    ) dut (
        .i_Clock         (clk),
        .i_Reset         (i_Reset),
        .i_SampleTick    (i_SampleTick),
        .i_AlgWriteEnable(i_AlgWriteEnable),
        .i_AlgWriteVoice (i_AlgWriteVoice),
        .i_AlgWriteData  (i_AlgWriteData),
        .i_OverrunClear  (i_OverrunClear),
        .o_RomAlgorithm  (o_RomAlgorithm),
        .o_RomOperator   (o_RomOperator),
        .i_SEL           (i_SEL),
        .i_MREN          (i_MREN),
        .i_FREN          (i_FREN),
        .o_Valid         (o_Valid),
        .o_Voice         (o_Voice),
        .o_Operator      (o_Operator),
        .o_SEL           (o_SEL),
        .o_MREN          (o_MREN),
        .o_FREN          (o_FREN),
        .o_Busy          (o_Busy),
        .o_FrameDone     (o_FrameDone),
        .o_Overrun       (o_Overrun)
    );

    // Registered algorithm ROM: word = rom_mem[alg*8 + op], {SEL, MREN, FREN}.
    logic [4:0] rom_mem [512];
    logic [8:0] rom_addr_q = '0;
    logic [4:0] rom_word;
    always @(posedge clk) rom_addr_q <= {o_RomAlgorithm, o_RomOperator};
    assign rom_word = rom_mem[rom_addr_q];
    assign i_SEL  = rom_word[4:2];
    assign i_MREN = rom_word[1];
    assign i_FREN = rom_word[0];

    typedef struct {
        int voice;
        int op;
        int alg;
        bit last;
    } step_t;

    step_t      exp_q[$];
    logic [5:0] mdl_tab [NV];
    bit         mdl_ovr = 1'b0;
    bit         mon_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        step_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (o_Valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 32'(o_Valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("voice", 32'(o_Voice), e.voice);
                        check("operator", 32'(o_Operator), e.op);
                        check("rom_addr", 32'(rom_addr_q), e.alg * 8 + e.op);
                        check("ctrl", 32'({o_SEL, o_MREN, o_FREN}),
                              32'(rom_mem[e.alg * 8 + e.op]));
                        check("frame_done", 32'(o_FrameDone), 32'(e.last));
                    end
                end else begin
                    check("idle_quiet", 32'({o_SEL, o_MREN, o_FREN, o_FrameDone}), 32'd0);
                end
            end
        end
    end

    task automatic clear_model();
        foreach (mdl_tab[i]) mdl_tab[i] = '0;
        mdl_ovr = 1'b0;
    endtask

    task automatic idle_write(input int v, input logic [5:0] d);
        i_AlgWriteEnable = 1'b1;
        i_AlgWriteVoice  = VW'(v);
        i_AlgWriteData   = d;
        step();
        i_AlgWriteEnable = 1'b0;
        mdl_tab[v] = d;
    endtask

    task automatic idle_clear();
        i_OverrunClear = 1'b1;
        step();
        i_OverrunClear = 1'b0;
        mdl_ovr = 1'b0;
        check("ovr_idle_clear", 32'(o_Overrun), 32'd0);
    endtask

    // Step s (0..STEPS-1) is the cycle issuing voice s/NO op s%NO; s == STEPS is the drain.
    task automatic run_frame(input int wr_step, input int wr_voice, input logic [5:0] wr_data,
                             input int ovr_step, input int clr_step, input int rst_step);
        int    nsteps;
        step_t e;
        nsteps = (rst_step >= 0) ? rst_step : STEPS;
        for (int k = 0; k < nsteps; k++) begin
            e.voice = k / NO;
            e.op    = k % NO;
            e.alg   = int'(mdl_tab[e.voice]);
            // A write lands before a voice is latched only if it precedes that voice's op-0 cycle.
            if (wr_step >= 0 && wr_voice == e.voice && wr_step < NO * e.voice) e.alg = int'(wr_data);
            e.last  = (k == STEPS - 1);
            exp_q.push_back(e);
        end
        i_SampleTick = 1'b1;
        step();
        i_SampleTick = 1'b0;
        check("first_busy", 32'(o_Busy), 32'd1);
        check("first_not_valid", 32'(o_Valid), 32'd0);
        for (int s = 0; s <= STEPS; s++) begin
            if (s == rst_step) begin
                i_Reset = 1'b1;
                step();
                i_Reset = 1'b0;
                check("rst_valid", 32'(o_Valid), 32'd0);
                check("rst_busy", 32'(o_Busy), 32'd0);
                check("rst_overrun", 32'(o_Overrun), 32'd0);
                check("rst_flushed", exp_q.size(), 32'd0);
                exp_q.delete();
                clear_model();
                return;
            end
            i_SampleTick     = (s == ovr_step);
            i_OverrunClear   = (s == clr_step);
            i_AlgWriteEnable = (s == wr_step);
            i_AlgWriteVoice  = VW'(wr_voice);
            i_AlgWriteData   = wr_data;
            if (s == ovr_step) mdl_ovr = 1'b1;
            else if (s == clr_step) mdl_ovr = 1'b0;
            if (s == wr_step) mdl_tab[wr_voice] = wr_data;
            step();
            i_SampleTick     = 1'b0;
            i_OverrunClear   = 1'b0;
            i_AlgWriteEnable = 1'b0;
            if (s == ovr_step || s == clr_step) check("ovr_flag", 32'(o_Overrun), 32'(mdl_ovr));
        end
        check("end_valid", 32'(o_Valid), 32'd0);
        check("end_busy", 32'(o_Busy), 32'd0);
        check("end_done", 32'(o_FrameDone), 32'd0);
        check("end_drained", exp_q.size(), 32'd0);
        check("end_overrun", 32'(o_Overrun), 32'(mdl_ovr));
        exp_q.delete();
    endtask

    initial begin : stimulus
        int ws, wv, os, cs;
        foreach (rom_mem[i]) rom_mem[i] = 5'($urandom());
        clear_model();

        repeat (3) step();
        check("reset_valid_busy", 32'({o_Valid, o_Busy, o_FrameDone, o_Overrun}), 32'd0);
        check("reset_rom_addr", 32'({o_RomAlgorithm, o_RomOperator}), 32'd0);
        check("reset_step", 32'({o_Voice, o_Operator, o_SEL, o_MREN, o_FREN}), 32'd0);
        i_Reset = 1'b0;
        mon_en  = 1'b1;
        step();

        // Unwritten table, then a single programmed voice.
        run_frame(-1, 0, 6'h00, -1, -1, -1);
        idle_write(3, 6'h2A);
        run_frame(-1, 0, 6'h00, -1, -1, -1);

        for (int i = 0; i < 8; i++) idle_write(int'($urandom_range(0, NV - 1)), 6'($urandom()));

        // Mid-voice write (op 2 of voice 5), write on op 0 of voice 7, write ahead of voice 9.
        run_frame(NO * 5 + 2, 5, 6'h11, -1, -1, -1);
        run_frame(NO * 7, 7, 6'h07, -1, -1, -1);
        run_frame(NO * 9 - 1, 9, 6'h29, -1, -1, -1);
        run_frame(-1, 0, 6'h00, -1, -1, -1);

        // Overrun: set mid-frame, clear, set in drain, then back-to-back tick with clear+set.
        run_frame(-1, 0, 6'h00, 100, -1, -1);
        idle_clear();
        run_frame(-1, 0, 6'h00, STEPS, -1, -1);
        run_frame(-1, 0, 6'h00, 10, 10, -1);
        run_frame(-1, 0, 6'h00, -1, 20, -1);

        // Reset mid-frame, then restart from voice 0 with a cleared table.
        run_frame(10, 20, 6'h15, -1, -1, 50);
        step();
        run_frame(-1, 0, 6'h00, -1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            ws = int'($urandom_range(0, STEPS));
            wv = int'($urandom_range(0, NV - 1));
            os = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, STEPS)) : -1;
            cs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, STEPS)) : -1;
            run_frame(ws, wv, 6'($urandom()), os, cs, -1);
        end

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
